// File: rtl/alu_pkg.sv
// alu_pkg: shared types and constants for the alu_issue slice.
// Holds the ALU opcode enum, the RV32I opcode/funct encodings used by
// the decoder, the issue-stage entry struct and the funct3 -> ALU op helper.
package alu_pkg;

    // Datapath width (only 32 is supported) and ALU opcode width
    localparam int XLEN = 32;
    localparam int OPW  = 4;

    // ALU opcode as seen by the combinational ALU; 10-15 are unused
    typedef enum logic [OPW-1:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLT  = 4'd2,
        ALU_SLTU = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_OR   = 4'd5,
        ALU_AND  = 4'd6,
        ALU_SLL  = 4'd7,
        ALU_SRL  = 4'd8,
        ALU_SRA  = 4'd9
    } alu_op_e;

    // Major opcodes handled by this block
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

    // funct3 encodings shared by OP and OP-IMM
    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SRL  = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    // funct7 encodings: base form and the alternate (sub/sra) form
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // One decoded instruction as held in the issue stage
    typedef struct packed {
        logic [XLEN-1:0] op_a;
        logic [XLEN-1:0] op_b;
        alu_op_e         alu_op;
        logic [4:0]      rd;
        logic            we;
        logic            illegal;
    } s1_entry_t;

    // Map funct3 to an ALU op; alt selects sub for 000 and sra for 101
    function automatic alu_op_e aluOpFromFunct3(input logic [2:0] funct3, input logic alt);
        alu_op_e op;
        op = ALU_ADD;
        case (funct3)
            F3_ADD:  op = alt ? ALU_SUB : ALU_ADD;
            F3_SLL:  op = ALU_SLL;
            F3_SLT:  op = ALU_SLT;
            F3_SLTU: op = ALU_SLTU;
            F3_XOR:  op = ALU_XOR;
            F3_SRL:  op = alt ? ALU_SRA : ALU_SRL;
            F3_OR:   op = ALU_OR;
            F3_AND:  op = ALU_AND;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/alu_issue_if.sv
// alu_issue_if: instruction intake, ALU drive and writeback signals of alu_issue.
// Signal names are written from the point of view of the alu_issue block:
// i_* are driven into it, o_* are driven by it.
// master = the alu_issue block itself, slave = its environment.
interface alu_issue_if;
    import alu_pkg::*;

    // Instruction intake handshake
    logic            i_valid;
    logic            o_ready;
    logic [31:0]     i_instr;
    logic [XLEN-1:0] i_rs1_data;
    logic [XLEN-1:0] i_rs2_data;

    // Combinational ALU connection
    logic [XLEN-1:0] o_op_a;
    logic [XLEN-1:0] o_op_b;
    logic [OPW-1:0]  o_alu_op;
    logic [XLEN-1:0] i_alu_data;

    // Writeback handshake
    logic            o_wb_valid;
    logic            i_wb_ready;
    logic [4:0]      o_rd_addr;
    logic            o_rd_we;
    logic [XLEN-1:0] o_rd_data;
    logic            o_illegal;

    modport master (
        input  i_valid, i_instr, i_rs1_data, i_rs2_data, i_alu_data, i_wb_ready,
        output o_ready, o_op_a, o_op_b, o_alu_op, o_wb_valid, o_rd_addr, o_rd_we,
               o_rd_data, o_illegal
    );

    modport slave (
        output i_valid, i_instr, i_rs1_data, i_rs2_data, i_alu_data, i_wb_ready,
        input  o_ready, o_op_a, o_op_b, o_alu_op, o_wb_valid, o_rd_addr, o_rd_we,
               o_rd_data, o_illegal
    );

endinterface

// File: rtl/alu_decode.sv
// alu_decode: combinational RV32I OP/OP-IMM decoder producing an issue entry.
// Optional macro ALU_ISSUE_ILLEGAL_EN enables funct7 checking and flags
// every non OP/OP-IMM opcode as illegal; without it decode looks at
// instr[30] only and unknown opcodes simply become a no-write add of zeros.
module alu_decode
    import alu_pkg::*;
(
    input  logic [31:0]     instr_i,
    input  logic [XLEN-1:0] rs1Data_i,
    input  logic [XLEN-1:0] rs2Data_i,
    output s1_entry_t       entry_o
);

    logic [2:0] funct3;
    logic [4:0] rdAddr;
    logic       isShiftImm;
    logic [4:0] unusedRs1Addr;

`ifdef ALU_ISSUE_ILLEGAL_EN
    logic [6:0] funct7;
    assign funct7 = instr_i[31:25];
`endif

    assign funct3        = instr_i[14:12];
    assign rdAddr        = instr_i[11:7];
    assign isShiftImm    = (funct3 == F3_SLL) || (funct3 == F3_SRL);
    // Register addresses arrive already resolved as rs1/rs2 data
    assign unusedRs1Addr = instr_i[19:15];

    // Decode one instruction into operands, ALU op, destination and flags
    always_comb begin
        entry_o        = '0;
        entry_o.alu_op = ALU_ADD;
        entry_o.rd     = rdAddr;
        case (instr_i[6:0])
            OPC_OP: begin
                entry_o.op_a   = rs1Data_i;
                entry_o.op_b   = rs2Data_i;
                entry_o.alu_op = aluOpFromFunct3(funct3, instr_i[30]);
                entry_o.we     = (rdAddr != 5'd0);
`ifdef ALU_ISSUE_ILLEGAL_EN
                entry_o.illegal = !((funct7 == F7_BASE) ||
                                    ((funct7 == F7_ALT) &&
                                     ((funct3 == F3_ADD) || (funct3 == F3_SRL))));
`endif
            end
            OPC_OP_IMM: begin
                entry_o.op_a = rs1Data_i;
                if (isShiftImm) begin
                    entry_o.op_b = {{(XLEN-5){1'b0}}, instr_i[24:20]};
                end else begin
                    entry_o.op_b = {{(XLEN-12){instr_i[31]}}, instr_i[31:20]};
                end
                entry_o.alu_op = aluOpFromFunct3(funct3, (funct3 == F3_SRL) && instr_i[30]);
                entry_o.we     = (rdAddr != 5'd0);
`ifdef ALU_ISSUE_ILLEGAL_EN
                if (funct3 == F3_SLL) begin
                    entry_o.illegal = (funct7 != F7_BASE);
                end else if (funct3 == F3_SRL) begin
                    entry_o.illegal = !((funct7 == F7_BASE) || (funct7 == F7_ALT));
                end
`endif
            end
            default: begin
`ifdef ALU_ISSUE_ILLEGAL_EN
                entry_o.illegal = 1'b1;
`endif
            end
        endcase
        if (entry_o.illegal) begin
            entry_o.we = 1'b0;
        end
    end

endmodule

// File: rtl/alu_issue.sv
// alu_issue: two-stage issue/writeback wrapper around a combinational ALU.
// S1 holds the decoded instruction and drives the ALU inputs; S2 captures
// the ALU result and presents it on a valid/ready writeback port.
// Optional macro ALU_ISSUE_ILLEGAL_EN: when defined, unsupported encodings
// are reported on o_illegal; otherwise o_illegal is tied 0.
module alu_issue
    import alu_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    alu_issue_if.master bus
);

    s1_entry_t       decoded;

    logic            s1Valid_q;
    logic            s1Valid_d;
    s1_entry_t       s1Entry_q;
    s1_entry_t       s1Entry_d;

    logic            s2Valid_q;
    logic            s2Valid_d;
    logic [4:0]      s2RdAddr_q;
    logic [4:0]      s2RdAddr_d;
    logic            s2RdWe_q;
    logic            s2RdWe_d;
    logic [XLEN-1:0] s2RdData_q;
    logic [XLEN-1:0] s2RdData_d;
`ifdef ALU_ISSUE_ILLEGAL_EN
    logic            s2Illegal_q;
    logic            s2Illegal_d;
`endif

    logic            s2Free;
    logic            s1Advance;
    logic            accept;

    alu_decode u_decode (
        .instr_i   (bus.i_instr),
        .rs1Data_i (bus.i_rs1_data),
        .rs2Data_i (bus.i_rs2_data),
        .entry_o   (decoded)
    );

    // Pipeline handshake: ready depends on downstream state, never on i_valid
    always_comb begin
        s2Free      = !s2Valid_q || bus.i_wb_ready;
        s1Advance   = s1Valid_q && s2Free;
        bus.o_ready = !s1Valid_q || s1Advance;
        accept      = bus.i_valid && bus.o_ready;
    end

    // S1 next state: load on accept, empty on advance, otherwise hold contents
    always_comb begin
        s1Valid_d = s1Valid_q;
        s1Entry_d = s1Entry_q;
        if (accept) begin
            s1Valid_d = 1'b1;
            s1Entry_d = decoded;
        end else if (s1Advance) begin
            s1Valid_d = 1'b0;
        end
    end

    // S1 registers; entry contents stay put while idle so the ALU inputs do not toggle
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s1Valid_q <= 1'b0;
            s1Entry_q <= '0;
        end else begin
            s1Valid_q <= s1Valid_d;
            s1Entry_q <= s1Entry_d;
        end
    end

    // S2 next state: capture the ALU result on advance, drop the beat once consumed
    always_comb begin
        s2Valid_d  = s2Valid_q;
        s2RdAddr_d = s2RdAddr_q;
        s2RdWe_d   = s2RdWe_q;
        s2RdData_d = s2RdData_q;
`ifdef ALU_ISSUE_ILLEGAL_EN
        s2Illegal_d = s2Illegal_q;
`endif
        if (s1Advance) begin
            s2Valid_d  = 1'b1;
            s2RdAddr_d = s1Entry_q.rd;
            s2RdWe_d   = s1Entry_q.we && !s1Entry_q.illegal;
            s2RdData_d = bus.i_alu_data;
`ifdef ALU_ISSUE_ILLEGAL_EN
            s2Illegal_d = s1Entry_q.illegal;
`endif
        end else if (bus.i_wb_ready) begin
            s2Valid_d = 1'b0;
        end
    end

    // S2 registers; contents are frozen while the consumer stalls
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s2Valid_q  <= 1'b0;
            s2RdAddr_q <= 5'd0;
            s2RdWe_q   <= 1'b0;
            s2RdData_q <= '0;
`ifdef ALU_ISSUE_ILLEGAL_EN
            s2Illegal_q <= 1'b0;
`endif
        end else begin
            s2Valid_q  <= s2Valid_d;
            s2RdAddr_q <= s2RdAddr_d;
            s2RdWe_q   <= s2RdWe_d;
            s2RdData_q <= s2RdData_d;
`ifdef ALU_ISSUE_ILLEGAL_EN
            s2Illegal_q <= s2Illegal_d;
`endif
        end
    end

    assign bus.o_op_a     = s1Entry_q.op_a;
    assign bus.o_op_b     = s1Entry_q.op_b;
    assign bus.o_alu_op   = s1Entry_q.alu_op;
    assign bus.o_wb_valid = s2Valid_q;
    assign bus.o_rd_addr  = s2RdAddr_q;
    assign bus.o_rd_we    = s2RdWe_q;
    assign bus.o_rd_data  = s2RdData_q;
`ifdef ALU_ISSUE_ILLEGAL_EN
    assign bus.o_illegal  = s2Illegal_q;
`else
    assign bus.o_illegal  = 1'b0;
`endif

endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue: directed and randomized checks of alu_issue against a
// behavioural model of the RV32I OP/OP-IMM semantics and a result queue.
// Honours ALU_ISSUE_ILLEGAL_EN the same way the design does.
module tb_alu_issue;

`ifdef ALU_ISSUE_ILLEGAL_EN
    localparam bit ILLEGAL_EN = 1'b1;
`else
    localparam bit ILLEGAL_EN = 1'b0;
`endif

    typedef struct {
        logic [31:0] opA;
        logic [31:0] opB;
        logic [3:0]  aluOp;
        logic [4:0]  rd;
        logic        we;
        logic        illegal;
        logic [31:0] data;
    } exp_t;

    logic clock;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    exp_t sbQ[$];

    alu_issue_if bus ();

    alu_issue dut (
        .i_clk (clock),
        .i_rst (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference ALU: 0 add,1 sub,2 slt,3 sltu,4 xor,5 or,6 and,7 sll,8 srl,9 sra
    function automatic logic [31:0] aluRef(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            4'd0: return a + b;
            4'd1: return a - b;
            4'd2: return {31'd0, ($signed(a) < $signed(b))};
            4'd3: return {31'd0, (a < b)};
            4'd4: return a ^ b;
            4'd5: return a | b;
            4'd6: return a & b;
            4'd7: return a << b[4:0];
            4'd8: return a >> b[4:0];
            4'd9: return $signed(a) >>> b[4:0];
            default: return 32'd0;
        endcase
    endfunction

    // The ALU attached to the block
    assign bus.i_alu_data = aluRef(bus.o_alu_op, bus.o_op_a, bus.o_op_b);

    // Instruction semantics: what one instruction must produce end to end
    function automatic exp_t refModel(input logic [31:0] instr, input logic [31:0] rs1, input logic [31:0] rs2);
        exp_t       e;
        logic [3:0] f3Map [8];
        logic [2:0] f3;
        logic [6:0] f7;
        logic       known;
        logic       legal;
        f3Map   = '{4'd0, 4'd7, 4'd2, 4'd3, 4'd4, 4'd8, 4'd5, 4'd6};
        f3      = instr[14:12];
        f7      = instr[31:25];
        e.opA   = 32'd0;
        e.opB   = 32'd0;
        e.aluOp = 4'd0;
        e.rd    = instr[11:7];
        known   = 1'b1;
        legal   = 1'b1;
        if (instr[6:0] == 7'b0110011) begin
            e.opA   = rs1;
            e.opB   = rs2;
            e.aluOp = f3Map[f3];
            if (instr[30] && f3 == 3'd0) e.aluOp = 4'd1;
            if (instr[30] && f3 == 3'd5) e.aluOp = 4'd9;
            legal = (f7 == 7'd0) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
        end else if (instr[6:0] == 7'b0010011) begin
            e.opA   = rs1;
            e.aluOp = f3Map[f3];
            if (f3 == 3'd1 || f3 == 3'd5) e.opB = {27'd0, instr[24:20]};
            else                          e.opB = {{20{instr[31]}}, instr[31:20]};
            if (instr[30] && f3 == 3'd5) e.aluOp = 4'd9;
            if (f3 == 3'd1) legal = (f7 == 7'd0);
            if (f3 == 3'd5) legal = (f7 == 7'd0) || (f7 == 7'h20);
        end else begin
            known = 1'b0;
            legal = 1'b0;
        end
        e.illegal = ILLEGAL_EN && !legal;
        e.we      = known && !e.illegal && (e.rd != 5'd0);
        e.data    = aluRef(e.aluOp, e.opA, e.opB);
        return e;
    endfunction

    function automatic logic [31:0] rType(input logic [6:0] f7, input logic [4:0] rs2a, input logic [4:0] rs1a,
                                          input logic [2:0] f3, input logic [4:0] rd);
        return {f7, rs2a, rs1a, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] iType(input logic [11:0] imm, input logic [4:0] rs1a,
                                          input logic [2:0] f3, input logic [4:0] rd);
        return {imm, rs1a, f3, rd, 7'b0010011};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [31:0] instr, input logic [31:0] rs1,
                                 input logic [31:0] rs2, input logic wbReady);
        bus.i_valid    = valid;
        bus.i_instr    = instr;
        bus.i_rs1_data = rs1;
        bus.i_rs2_data = rs2;
        bus.i_wb_ready = wbReady;
    endtask

    // One clock: score the writeback beat and intake, then check what the edge left behind
    task automatic clockCycle();
        exp_t        e;
        exp_t        front;
        logic        accepted;
        logic        fired;
        logic        held;
        logic [31:0] heldData;
        logic [4:0]  heldRd;
        #1;
        accepted = !reset && bus.i_valid && bus.o_ready;
        fired    = !reset && bus.o_wb_valid && bus.i_wb_ready;
        held     = !reset && bus.o_wb_valid && !bus.i_wb_ready;
        heldData = bus.o_rd_data;
        heldRd   = bus.o_rd_addr;
        if (fired) begin
            if (sbQ.size() == 0) begin
                checkOutput("wb_unexpected", bus.o_wb_valid, 32'd0);
            end else begin
                front = sbQ.pop_front();
                checkOutput("wb_rd_addr", bus.o_rd_addr, front.rd);
                checkOutput("wb_rd_we", bus.o_rd_we, front.we);
                checkOutput("wb_rd_data", bus.o_rd_data, front.data);
                checkOutput("wb_illegal", bus.o_illegal, front.illegal);
            end
        end
        if (accepted) begin
            e = refModel(bus.i_instr, bus.i_rs1_data, bus.i_rs2_data);
            sbQ.push_back(e);
        end
        @(posedge clock);
        #1;
        if (reset) begin
            sbQ.delete();
        end else begin
            if (held) begin
                checkOutput("wb_hold_valid", bus.o_wb_valid, 32'd1);
                checkOutput("wb_hold_data", bus.o_rd_data, heldData);
                checkOutput("wb_hold_rd", bus.o_rd_addr, heldRd);
            end
            if (accepted) begin
                checkOutput("s1_op_a", bus.o_op_a, e.opA);
                checkOutput("s1_op_b", bus.o_op_b, e.opB);
                checkOutput("s1_alu_op", bus.o_alu_op, e.aluOp);
            end
        end
    endtask

    // Issue a single instruction into an idle pipe and follow it to writeback
    task automatic issueOne(input string tag, input logic [31:0] instr, input logic [31:0] rs1, input logic [31:0] rs2,
                            input logic [3:0] expAlu, input logic [31:0] expOpB, input logic [31:0] expData);
        applyStimulus(1'b1, instr, rs1, rs2, 1'b1);
        #1;
        checkOutput({tag, "_ready"}, bus.o_ready, 32'd1);
        clockCycle();
        applyStimulus(1'b0, 32'd0, 32'd0, 32'd0, 1'b1);
        checkOutput({tag, "_alu_op"}, bus.o_alu_op, expAlu);
        checkOutput({tag, "_op_b"}, bus.o_op_b, expOpB);
        clockCycle();
        checkOutput({tag, "_wb_valid"}, bus.o_wb_valid, 32'd1);
        checkOutput({tag, "_rd_data"}, bus.o_rd_data, expData);
    endtask

    initial begin
        logic [31:0] instr;
        logic [31:0] i2Instr;
        logic [31:0] i3Instr;
        exp_t        i2Exp;
        int          sel;
        logic [6:0]  f7;

        // Reset state
        reset = 1'b1;
        applyStimulus(1'b0, 32'd0, 32'd0, 32'd0, 1'b0);
        clockCycle();
        clockCycle();
        reset = 1'b0;
        checkOutput("rst_ready", bus.o_ready, 32'd1);
        checkOutput("rst_wb_valid", bus.o_wb_valid, 32'd0);
        checkOutput("rst_op_a", bus.o_op_a, 32'd0);
        checkOutput("rst_op_b", bus.o_op_b, 32'd0);
        checkOutput("rst_alu_op", bus.o_alu_op, 32'd0);
        checkOutput("rst_rd_addr", bus.o_rd_addr, 32'd0);
        checkOutput("rst_rd_we", bus.o_rd_we, 32'd0);
        checkOutput("rst_rd_data", bus.o_rd_data, 32'd0);
        checkOutput("rst_illegal", bus.o_illegal, 32'd0);

        // Directed single instructions
        issueOne("add", rType(7'h00, 5'd2, 5'd1, 3'd0, 5'd3), 32'd5, 32'd7, 4'd0, 32'd7, 32'd12);
        checkOutput("add_rd_addr", bus.o_rd_addr, 32'd3);
        checkOutput("add_rd_we", bus.o_rd_we, 32'd1);
        issueOne("sub", rType(7'h20, 5'd2, 5'd1, 3'd0, 5'd4), 32'd3, 32'd5, 4'd1, 32'd5, 32'hFFFF_FFFE);
        issueOne("addi", iType(12'hFFF, 5'd1, 3'd0, 5'd5), 32'd1, 32'd0, 4'd0, 32'hFFFF_FFFF, 32'd0);
        issueOne("srai", iType({7'h20, 5'd4}, 5'd1, 3'd5, 5'd6), 32'h8000_0000, 32'd0, 4'd9, 32'd4, 32'hF800_0000);
        issueOne("load", {12'd0, 5'd1, 3'b010, 5'd7, 7'b0000011}, 32'd9, 32'd9, 4'd0, 32'd0, 32'd0);
        checkOutput("load_rd_we", bus.o_rd_we, 32'd0);
        checkOutput("load_illegal", bus.o_illegal, ILLEGAL_EN);
        issueOne("mul", rType(7'h01, 5'd2, 5'd1, 3'd0, 5'd8), 32'd6, 32'd7, 4'd0, 32'd7, 32'd13);
        checkOutput("mul_rd_we", bus.o_rd_we, !ILLEGAL_EN);
        checkOutput("mul_illegal", bus.o_illegal, ILLEGAL_EN);

        // Back-to-back throughput with the consumer always ready
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, rType(7'h00, 5'd2, 5'd1, 3'($urandom_range(0, 7)), 5'(i + 10)),
                          $urandom, $urandom, 1'b1);
            #1;
            checkOutput("b2b_ready", bus.o_ready, 32'd1);
            clockCycle();
        end

        // Stall: consumer not ready, third instruction must be held off
        applyStimulus(1'b0, 32'd0, 32'd0, 32'd0, 1'b1);
        clockCycle();
        clockCycle();
        applyStimulus(1'b1, rType(7'h00, 5'd2, 5'd1, 3'd4, 5'd11), 32'h1234_5678, 32'h0F0F_0F0F, 1'b0);
        clockCycle();
        i2Instr = iType(12'h123, 5'd1, 3'd6, 5'd12);
        i2Exp   = refModel(i2Instr, 32'hA000_0001, 32'd0);
        applyStimulus(1'b1, i2Instr, 32'hA000_0001, 32'd0, 1'b0);
        #1;
        checkOutput("stall_ready_2nd", bus.o_ready, 32'd1);
        clockCycle();
        i3Instr = rType(7'h20, 5'd2, 5'd1, 3'd5, 5'd13);
        applyStimulus(1'b1, i3Instr, 32'hF000_0000, 32'd3, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #1;
            checkOutput("stall_ready_3rd", bus.o_ready, 32'd0);
            checkOutput("stall_op_a", bus.o_op_a, i2Exp.opA);
            checkOutput("stall_op_b", bus.o_op_b, i2Exp.opB);
            checkOutput("stall_alu_op", bus.o_alu_op, i2Exp.aluOp);
            clockCycle();
        end
        applyStimulus(1'b1, i3Instr, 32'hF000_0000, 32'd3, 1'b1);
        clockCycle();
        applyStimulus(1'b0, 32'd0, 32'd0, 32'd0, 1'b1);
        for (int i = 0; i < 4; i++) clockCycle();
        checkOutput("stall_drained", sbQ.size(), 32'd0);

        // Reset with both stages occupied
        applyStimulus(1'b1, rType(7'h00, 5'd2, 5'd1, 3'd0, 5'd14), 32'd1, 32'd2, 1'b0);
        clockCycle();
        applyStimulus(1'b1, rType(7'h00, 5'd2, 5'd1, 3'd6, 5'd15), 32'd4, 32'd8, 1'b0);
        clockCycle();
        checkOutput("pre_rst_wb_valid", bus.o_wb_valid, 32'd1);
        checkOutput("pre_rst_ready", bus.o_ready, 32'd0);
        reset = 1'b1;
        applyStimulus(1'b0, 32'd0, 32'd0, 32'd0, 1'b0);
        clockCycle();
        reset = 1'b0;
        checkOutput("mid_rst_wb_valid", bus.o_wb_valid, 32'd0);
        checkOutput("mid_rst_ready", bus.o_ready, 32'd1);
        checkOutput("mid_rst_op_a", bus.o_op_a, 32'd0);
        checkOutput("mid_rst_op_b", bus.o_op_b, 32'd0);
        checkOutput("mid_rst_alu_op", bus.o_alu_op, 32'd0);
        checkOutput("mid_rst_rd_data", bus.o_rd_data, 32'd0);
        checkOutput("mid_rst_rd_addr", bus.o_rd_addr, 32'd0);
        checkOutput("mid_rst_rd_we", bus.o_rd_we, 32'd0);
        applyStimulus(1'b0, 32'd0, 32'd0, 32'd0, 1'b1);
        clockCycle();
        checkOutput("post_rst_no_wb", bus.o_wb_valid, 32'd0);

        // Destination x0 still produces data but never writes
        issueOne("x0", rType(7'h00, 5'd2, 5'd1, 3'd0, 5'd0), 32'd9, 32'd4, 4'd0, 32'd4, 32'd13);
        checkOutput("x0_rd_addr", bus.o_rd_addr, 32'd0);
        checkOutput("x0_rd_we", bus.o_rd_we, 32'd0);

        // Randomized traffic with random consumer back-pressure
        for (int i = 0; i < 300; i++) begin
            sel = $urandom_range(0, 9);
            case ($urandom_range(0, 3))
                0:       f7 = 7'h20;
                1:       f7 = 7'h01;
                default: f7 = 7'h00;
            endcase
            if (sel < 5) begin
                instr = rType(f7, 5'($urandom), 5'($urandom), 3'($urandom), 5'($urandom));
            end else if (sel < 9) begin
                instr = iType(12'($urandom), 5'($urandom), 3'($urandom), 5'($urandom));
                if (instr[14:12] == 3'd1 || instr[14:12] == 3'd5) instr[31:25] = f7;
            end else begin
                instr = $urandom;
            end
            applyStimulus($urandom_range(0, 3) != 0, instr, $urandom, $urandom, $urandom_range(0, 3) != 0);
            clockCycle();
        end
        applyStimulus(1'b0, 32'd0, 32'd0, 32'd0, 1'b1);
        for (int i = 0; i < 4; i++) clockCycle();
        checkOutput("final_drained", sbQ.size(), 32'd0);
        checkOutput("final_wb_valid", bus.o_wb_valid, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_issue.md
Name: alu_issue

Overview:
- Initiator side of the ALU operand/opcode interface.
- Accepts RV32I OP/OP-IMM instructions plus register-file operands over a valid/ready handshake and decodes them into the 4-bit ALU opcode (0 add, 1 sub, 2 slt, 3 sltu, 4 xor, 5 or, 6 and, 7 sll, 8 srl, 9 sra, 10-15 unused).
- Drives the combinational ALU from a registered issue stage.
- Captures the ALU result into a registered writeback stage with its own valid/ready handshake.

Parameters:
- XLEN, 32, datapath width; only 32 supported.
- OPW, 4, ALU opcode width.

Ports:
- i_clk  in  1  clock; all state updates on rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_valid  in  1  instruction/operands valid.
- o_ready  out  1  block can accept an instruction this cycle.
- i_instr  in  32  instruction word.
- i_rs1_data  in  32  rs1 value.
- i_rs2_data  in  32  rs2 value.
- o_op_a  out  32  ALU operand A (registered).
- o_op_b  out  32  ALU operand B (registered).
- o_alu_op  out  4  ALU opcode (registered).
- i_alu_data  in  32  combinational ALU result for current o_op_a/o_op_b/o_alu_op.
- o_wb_valid  out  1  writeback entry valid.
- i_wb_ready  in  1  consumer accepts writeback.
- o_rd_addr  out  5  destination register.
- o_rd_we  out  1  write enable; 0 when rd=x0 or instruction unsupported.
- o_rd_data  out  32  result.
- o_illegal  out  1  unsupported-instruction flag (only with macro; tied 0 otherwise).

Behaviour:
- Two registered stages: S1 (issue, drives ALU) and S2 (writeback).
- Reset: all valids 0, all outputs 0; o_alu_op=0 (add). Reset mid-operation discards both in-flight entries, with no writeback.
- Handshakes:
  - S2 is free when !s2_valid or i_wb_ready.
  - S1 advances into S2 when s1_valid and S2 is free.
  - o_ready = !s1_valid or S1 advances. This is combinational from i_wb_ready; there is no path from i_valid to o_ready.
- Accept on i_valid&&o_ready at edge N:
  - S1 holds the decoded entry from N+1; ALU inputs are valid during cycle N+1.
  - i_alu_data is captured into o_rd_data at edge N+2.
  - o_wb_valid is high from N+2 until consumed.
- Throughput: 1 instruction/cycle while i_wb_ready=1.
- Stall: with i_wb_ready=0, S2 holds and S1 holds. o_op_a/o_op_b/o_alu_op stay stable while S1 is valid and stalled. Third instruction sees o_ready=0.
- o_wb_valid never drops without i_wb_ready; S2 contents are stable while stalled.
- Decode:
  - opcode 0110011 (OP): op_b = rs2.
  - opcode 0010011 (OP-IMM): op_b = sign-extended instr[31:20]; for funct3 001/101, op_b = zero-extended instr[24:20].
  - op_a = rs1 in both cases.
- funct3 mapping: 000 add (OP with instr[30]=1 gives sub; OP-IMM never sub), 001 sll, 010 slt, 011 sltu, 100 xor, 101 srl (instr[30]=1 gives sra), 110 or, 111 and.
- Unsupported opcode: entry still flows through the pipeline (one writeback beat) with alu_op=0, op_a=op_b=0, o_rd_we=0.
- rd=x0: o_rd_addr=0, o_rd_we=0, data still produced.
- S1 idle (s1_valid=0): o_op_a/o_op_b/o_alu_op hold their last value; no toggling required.

Optional Feature:
- Macro: ALU_ISSUE_ILLEGAL_EN.
- Defined:
  - OP with funct7 not in {0000000, 0100000}, or with funct7=0100000 and funct3 not in {000, 101}, is illegal.
  - OP-IMM shifts with instr[31:25] not in {0000000, 0100000 for 101} are illegal.
  - Any other opcode is illegal.
  - Illegal entries writeback with o_illegal=1, o_rd_we=0.
- Undefined: the above funct7 checks are skipped, decode uses instr[30] only, non-OP opcodes behave as unsupported, and o_illegal is tied 0.

Decomposition:
- Package alu_pkg:
  - alu_op_e enum (ALU_ADD=0 … ALU_SRA=9).
  - opcode constants OPC_OP=7'b0110011, OPC_OP_IMM=7'b0010011.
  - funct3 constants.
  - s1_entry_t struct: op_a, op_b, alu_op, rd, we, illegal.
- Sub-module alu_decode: purely combinational, instr+rs1+rs2 → s1_entry_t. The parent holds the stage registers and handshake.

Test Plan:
- ADD x3,x1,x2 with rs1=5, rs2=7, ALU model attached → after 2 cycles o_wb_valid=1, o_rd_addr=3, o_rd_data=12, o_rd_we=1; o_alu_op=0 during cycle N+1.
- SUB (funct7=0100000) with rs1=3, rs2=5 → o_alu_op=1, o_rd_data=32'hFFFFFFFE.
- ADDI imm=12'hFFF with rs1=1 → o_op_b=32'hFFFFFFFF, result 0. SRAI shamt=4 on rs1=32'h80000000 → o_alu_op=9, o_op_b=4, result 32'hF8000000.
- Back-to-back 3 instructions with i_wb_ready=0 → o_ready=0 on the third cycle and S1 outputs stable. Release i_wb_ready → results retire in order, one per cycle, none lost or duplicated.
- Opcode 0000011 (load) → one writeback beat with o_rd_we=0. With ALU_ISSUE_ILLEGAL_EN, o_illegal=1. R-type funct7=0000001 → o_illegal=1 only with the macro.
- Assert i_rst for 1 cycle with both stages valid → next cycle o_wb_valid=0, o_ready=1, all outputs 0; rd=x0 instruction afterwards → o_rd_we=0.
